// File: rtl/turn_sequencer.sv
// turn_sequencer: two-player game sequencer for the scoreboard display.
//
// Detects rising edges on the debounced start/made/miss buttons and owns the game state:
// alternates turns, counts scores, runs a shot clock and declares the winner.
//
// Parameters:
//   WIN_SCORE   score that ends the game (1..15)
//   SHOT_TICKS  shot-clock reload value in ticks (1..31)
//   TICK_DIV    PCLK cycles per shot-clock tick (>= 2)
//
// Ports:
//   PCLK         clock
//   PRESET       synchronous active-high reset
//   start        button level; rising edge starts or clears a game
//   made         button level; rising edge scores for the current player
//   miss         button level; rising edge passes the turn
//   player1      player 1 score, zero-extended
//   player2      player 2 score, zero-extended
//   whichplayer  0 = player 1 shoots, 1 = player 2 shoots
//   winner       0 = none, 1 = player 1, 2 = player 2
//   shot_clock   remaining ticks, 0 outside PLAY
//   state        0 = IDLE, 1 = PLAY, 2 = WIN
//
// Build option: define SHOT_CLOCK_EN to include the shot clock and timeout. Without it the
// shot_clock output is tied to 0 and turns change only on made or miss.
module turn_sequencer #(
  parameter int unsigned WIN_SCORE  = 10,
  parameter int unsigned SHOT_TICKS = 24,
  parameter int unsigned TICK_DIV   = 25000000
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        start,
  input  logic        made,
  input  logic        miss,
  output logic [31:0] player1,
  output logic [31:0] player2,
  output logic [31:0] whichplayer,
  output logic [31:0] winner,
  output logic [4:0]  shot_clock,
  output logic [1:0]  state
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPlay = 2'd1;
  localparam logic [1:0] StWin  = 2'd2;

  localparam logic [3:0] WinScore = 4'(WIN_SCORE);

  if ((WIN_SCORE < 1) || (WIN_SCORE > 15) || (SHOT_TICKS < 1) || (SHOT_TICKS > 31) ||
      (TICK_DIV < 2)) begin : g_bad_params
    $error("turn_sequencer: parameter out of legal range");
  end

  logic [1:0] state_q, state_d;
  logic [3:0] p1_q, p1_d;
  logic [3:0] p2_q, p2_d;
  logic       who_q, who_d;
  logic [1:0] win_q, win_d;

  // History flops reset to 1 so a button held through reset produces no edge.
  logic start_q, made_q, miss_q;
  logic start_rise, made_rise, miss_rise;

`ifdef SHOT_CLOCK_EN
  localparam int unsigned TickW      = $clog2(TICK_DIV);
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
  localparam logic [4:0] ShotReload  = 5'(SHOT_TICKS);

  logic [4:0]       shot_q, shot_d;
  logic [TickW-1:0] tick_q, tick_d;
`endif

  logic turn_switch;
  logic clear_game;

  assign start_rise = start & ~start_q;
  assign made_rise  = made & ~made_q;
  assign miss_rise  = miss & ~miss_q;

  always_comb begin
    state_d     = state_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    who_d       = who_q;
    win_d       = win_q;
    turn_switch = 1'b0;
    clear_game  = 1'b0;
`ifdef SHOT_CLOCK_EN
    shot_d      = shot_q;
    tick_d      = tick_q;
`endif

    case (state_q)
      StIdle: begin
        if (start_rise) begin
          clear_game = 1'b1;
        end
      end
      StPlay: begin
        // Priority start > made > miss > timeout; only one event acts per cycle.
        if (start_rise) begin
          clear_game = 1'b1;
        end else if (made_rise) begin
          if (!who_q) begin
            p1_d = p1_q + 4'd1;
          end else begin
            p2_d = p2_q + 4'd1;
          end
          if (((who_q ? p2_q : p1_q) + 4'd1) == WinScore) begin
            // whichplayer is held so the display keeps showing the winning shooter.
            state_d = StWin;
            win_d   = who_q ? 2'd2 : 2'd1;
`ifdef SHOT_CLOCK_EN
            shot_d  = 5'd0;
            tick_d  = '0;
`endif
          end else begin
            turn_switch = 1'b1;
          end
        end else if (miss_rise) begin
          turn_switch = 1'b1;
        end else begin
`ifdef SHOT_CLOCK_EN
          if (tick_q == TickLast) begin
            tick_d = '0;
            if (shot_q > 5'd1) begin
              shot_d = shot_q - 5'd1;
            end else begin
              // Expiry is a miss; the display never shows 0 while in PLAY.
              turn_switch = 1'b1;
            end
          end else begin
            tick_d = tick_q + TickW'(1);
          end
`endif
        end
      end
      StWin: begin
        if (start_rise) begin
          state_d = StIdle;
          p1_d    = 4'd0;
          p2_d    = 4'd0;
          who_d   = 1'b0;
          win_d   = 2'd0;
`ifdef SHOT_CLOCK_EN
          shot_d  = 5'd0;
          tick_d  = '0;
`endif
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (clear_game) begin
      state_d = StPlay;
      p1_d    = 4'd0;
      p2_d    = 4'd0;
      who_d   = 1'b0;
      win_d   = 2'd0;
`ifdef SHOT_CLOCK_EN
      shot_d  = ShotReload;
      tick_d  = '0;
`endif
    end

    if (turn_switch) begin
      who_d  = ~who_q;
`ifdef SHOT_CLOCK_EN
      shot_d = ShotReload;
      tick_d = '0;
`endif
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= StIdle;
      p1_q    <= 4'd0;
      p2_q    <= 4'd0;
      who_q   <= 1'b0;
      win_q   <= 2'd0;
      start_q <= 1'b1;
      made_q  <= 1'b1;
      miss_q  <= 1'b1;
`ifdef SHOT_CLOCK_EN
      shot_q  <= 5'd0;
      tick_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      who_q   <= who_d;
      win_q   <= win_d;
      start_q <= start;
      made_q  <= made;
      miss_q  <= miss;
`ifdef SHOT_CLOCK_EN
      shot_q  <= shot_d;
      tick_q  <= tick_d;
`endif
    end
  end

  assign player1     = {28'd0, p1_q};
  assign player2     = {28'd0, p2_q};
  assign whichplayer = {31'd0, who_q};
  assign winner      = {30'd0, win_q};
  assign state       = state_q;
`ifdef SHOT_CLOCK_EN
  assign shot_clock  = shot_q;
`else
  assign shot_clock  = 5'd0;
`endif

endmodule
